prio_encoder_stream: RTL and testbench
======================================

Name: prio_encoder_stream

Overview:
- Parametrised, registered successor to the combinational 8:3 priority encoder.
- Accepts an N-bit one-hot or multi-hot request word over a valid/ready handshake and returns the winning bit index one cycle later over a second valid/ready handshake.
- Status flags report zero-request and multi-request inputs.
- Has a selectable round-robin mode for fair arbitration. Used wherever a request vector must be reduced to an index in a pipelined path.

Parameters:
- N, 8: request width; legal range 2..256.
- RR_MODE, 0: 0 = fixed priority, highest index wins; 1 = round-robin priority.
- W, $clog2(N): index width. Localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  N  request vector.
- in_valid  input  1  `in` is valid this cycle.
- in_ready  output  1  block can accept `in` this cycle.
- out  output  W  encoded winning index.
- out_valid  output  1  result registers hold a result.
- out_ready  input  1  downstream accepts the result.
- out_none  output  1  captured vector was all zeros.
- out_multi  output  1  captured vector had two or more bits set.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out=0, out_valid=0, out_none=0, out_multi=0.
  - Round-robin pointer ptr = N-1.
  - in_ready reads 1 once reset is released.
- Single-entry output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Capture occurs when in_valid && in_ready.
  - Latency: result is visible with out_valid=1 on the edge after capture.
- Hold: while out_valid && !out_ready, out, out_none and out_multi stay stable, and in_ready=0.
- Simultaneous accept and capture (out_valid && out_ready && in_valid): the new result replaces the old one in the same edge, with no bubble. This gives full throughput of one result per cycle.
- Accept without a new capture: out_valid clears on the next edge. The out value need not clear.
- Fixed mode (RR_MODE=0): out = index of the highest set bit. Example: in=8'b10101000 gives out=7.
- Round-robin mode (RR_MODE=1):
  - Search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1. The first set bit wins.
  - On a capture with a nonzero vector, ptr <= (winner == 0) ? N-1 : winner-1. The winner therefore becomes lowest priority next time.
  - ptr is unchanged on a zero-vector capture and when no capture occurs.
  - Because reset sets ptr=N-1, the first grant after reset matches fixed mode.
- Zero vector: out_none=1, out=0, out_multi=0. out_valid still asserts, so the result must still be handshaken.
- out_multi = 1 when the popcount of the captured vector is 2 or more. It is independent of mode.
- Flags are registered alongside out and share its valid/hold rules.
- Reset mid-transfer: a pending result is discarded and ptr returns to N-1. No partial state survives.
- in is sampled only on capture edges. Changes while in_ready=0 are ignored.

Test Plan:
- Fixed, N=8: walk one-hot 8'b00000001 .. 8'b10000000 with out_ready=1 held high.
  - Required: out=0..7 in order, each one cycle after capture.
  - out_valid stays continuously high after the first capture.
  - out_none=0 and out_multi=0 throughout.
- Fixed, N=8: in=8'b00000000 -> out=0, out_none=1. Then in=8'b10101000 -> out=7, out_multi=1, out_none=0.
- Backpressure: capture 8'b00010000, then hold out_ready=0 for 3 cycles while driving in_valid=1 with 8'b00000010.
  - Required: out=4 stable and in_ready=0 for those cycles.
  - On the cycle out_ready=1: the next edge shows out=1, with no bubble and no lost word.
- RR_MODE=1, N=8: apply in=8'b10000001 four times back-to-back.
  - Required: out=7,0,7,0 and out_multi=1 each time.
  - Then in=8'b00000000: out_none=1 and ptr unchanged, so the next 8'b10000001 gives out=7.
- Parametrisation, N=16 fixed: in=16'h8001 -> out=15, 4-bit width. Also N=5 RR: in=5'b11111 five times -> out=4,3,2,1,0.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1 and out_ready=0.
  - Required: out_valid=0 immediately, with no clock edge needed.
  - After release, RR mode with in=8'b10000001 -> out=7.

Source files
------------

// File: rtl/prio_encoder_stream.sv
// rtl/prio_encoder_stream.sv - registered N-bit priority encoder with valid/ready handshakes and optional round-robin
module prio_encoder_stream #(
    parameter int N = 8,
    parameter int RR_MODE = 0,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_none,
    output logic         out_multi
);

    logic [W-1:0] ptr;
    logic [W-1:0] search_start;
    logic [W-1:0] cur;
    logic [W-1:0] win;
    logic         found;
    logic         capture;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    // Walk downward from the start index with wrap; fixed mode always starts at the top bit.
    always_comb begin
        search_start = (RR_MODE != 0) ? ptr : W'(N - 1);
        win          = '0;
        found        = 1'b0;
        cur          = search_start;
        for (int k = 0; k < N; k++) begin
            if (!found && in[cur]) begin
                win   = cur;
                found = 1'b1;
            end
            cur = (cur == '0) ? W'(N - 1) : cur - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            out_none  <= 1'b0;
            out_multi <= 1'b0;
            ptr       <= W'(N - 1);
        end else begin
            if (capture) begin
                out_valid <= 1'b1;
                out       <= win;
                out_none  <= ~|in;
                // Clearing the lowest set bit leaves something only if two or more bits were set.
                out_multi <= |(in & (in - N'(1)));
                if (RR_MODE != 0 && found) begin
                    ptr <= (win == '0) ? W'(N - 1) : win - W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_stream.sv
// tb/tb_prio_encoder_stream.sv - scoreboard bench for prio_encoder_stream in fixed, round-robin and resized builds
module tb_prio_encoder_stream;

    typedef struct {
        int   idx;
        logic none;
        logic multi;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    logic [7:0]  f8_in = '0;
    logic        f8_iv = 1'b0, f8_ir, f8_ov, f8_or = 1'b0, f8_none, f8_multi;
    logic [2:0]  f8_out;
    logic [7:0]  r8_in = '0;
    logic        r8_iv = 1'b0, r8_ir, r8_ov, r8_or = 1'b0, r8_none, r8_multi;
    logic [2:0]  r8_out;
    logic [15:0] g16_in = '0;
    logic        g16_iv = 1'b0, g16_ir, g16_ov, g16_or = 1'b0, g16_none, g16_multi;
    logic [3:0]  g16_out;
    logic [4:0]  r5_in = '0;
    logic        r5_iv = 1'b0, r5_ir, r5_ov, r5_or = 1'b0, r5_none, r5_multi;
    logic [2:0]  r5_out;

    prio_encoder_stream #(.N(8), .RR_MODE(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .in(f8_in), .in_valid(f8_iv), .in_ready(f8_ir),
        .out(f8_out), .out_valid(f8_ov), .out_ready(f8_or), .out_none(f8_none), .out_multi(f8_multi));
    prio_encoder_stream #(.N(8), .RR_MODE(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .in(r8_in), .in_valid(r8_iv), .in_ready(r8_ir),
        .out(r8_out), .out_valid(r8_ov), .out_ready(r8_or), .out_none(r8_none), .out_multi(r8_multi));
    prio_encoder_stream #(.N(16), .RR_MODE(0)) u_fix16 (
        .clk(clk), .rst_n(rst_n), .in(g16_in), .in_valid(g16_iv), .in_ready(g16_ir),
        .out(g16_out), .out_valid(g16_ov), .out_ready(g16_or), .out_none(g16_none), .out_multi(g16_multi));
    prio_encoder_stream #(.N(5), .RR_MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .in(r5_in), .in_valid(r5_iv), .in_ready(r5_ir),
        .out(r5_out), .out_valid(r5_ov), .out_ready(r5_or), .out_none(r5_none), .out_multi(r5_multi));

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({f8_ov, f8_out, f8_none, f8_multi} !== 6'b0) begin
            bad++;
            $display("FAIL reset_fix8 got=%b want=000000", {f8_ov, f8_out, f8_none, f8_multi});
        end
        total++;
        if ({r8_ov, r8_out, r8_none, r8_multi} !== 6'b0) begin
            bad++;
            $display("FAIL reset_rr8 got=%b want=000000", {r8_ov, r8_out, r8_none, r8_multi});
        end
        total++;
        if ({g16_ov, g16_out, r5_ov, r5_out} !== 9'b0) begin
            bad++;
            $display("FAIL reset_other got=%b want=000000000", {g16_ov, g16_out, r5_ov, r5_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({f8_ir, r8_ir} !== 2'b11) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=11", {f8_ir, r8_ir});
        end
    endtask

    task automatic test_walk();
        exp_t e;
        f8_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f8_in = 8'(1 << i);
            f8_iv = 1'b1;
            exp_q.push_back('{i, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            total++;
            if (f8_ov !== 1'b1) begin
                bad++;
                $display("FAIL walk_valid step=%0d got=%b want=1", i, f8_ov);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL walk_queue step=%0d got=empty want=entry", i);
            end else begin
                e = exp_q.pop_front();
                if (f8_out !== 3'(e.idx) || f8_none !== e.none || f8_multi !== e.multi) begin
                    bad++;
                    $display("FAIL walk_result step=%0d got=%0d/%b/%b want=%0d/%b/%b",
                             i, f8_out, f8_none, f8_multi, e.idx, e.none, e.multi);
                end
            end
        end
        f8_iv = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (f8_ov !== 1'b0) begin
            bad++;
            $display("FAIL walk_drain got=%b want=0", f8_ov);
        end
    endtask

    task automatic test_zero_multi();
        logic [7:0] vecs[2] = '{8'b00000000, 8'b10101000};
        exp_t e;
        exp_q.push_back('{0, 1'b1, 1'b0});
        exp_q.push_back('{7, 1'b0, 1'b1});
        f8_or = 1'b1;
        for (int i = 0; i < 2; i++) begin
            f8_in = vecs[i];
            f8_iv = 1'b1;
            @(posedge clk);
            #1;
            total++;
            e = exp_q.pop_front();
            if (f8_ov !== 1'b1 || f8_out !== 3'(e.idx) || f8_none !== e.none || f8_multi !== e.multi) begin
                bad++;
                $display("FAIL zero_multi step=%0d got=v%b %0d/%b/%b want=v1 %0d/%b/%b",
                         i, f8_ov, f8_out, f8_none, f8_multi, e.idx, e.none, e.multi);
            end
        end
        f8_iv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        exp_t e;
        f8_or = 1'b0;
        f8_in = 8'b00010000;
        f8_iv = 1'b1;
        exp_q.push_back('{4, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        total++;
        e = exp_q.pop_front();
        if (f8_ov !== 1'b1 || f8_out !== 3'(e.idx)) begin
            bad++;
            $display("FAIL bp_capture got=v%b out=%0d want=v1 out=%0d", f8_ov, f8_out, e.idx);
        end
        f8_in = 8'b00000010;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (f8_ir !== 1'b0 || f8_ov !== 1'b1 || f8_out !== 3'd4 || f8_none !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got=rdy%b v%b out=%0d want=rdy0 v1 out=4",
                         c, f8_ir, f8_ov, f8_out);
            end
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        f8_or = 1'b1;
        #1;
        total++;
        if (f8_ir !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready got=%b want=1", f8_ir);
        end
        exp_q.push_back('{1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        total++;
        e = exp_q.pop_front();
        if (f8_ov !== 1'b1 || f8_out !== 3'(e.idx)) begin
            bad++;
            $display("FAIL bp_next got=v%b out=%0d want=v1 out=%0d", f8_ov, f8_out, e.idx);
        end
        f8_iv = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (f8_ov !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain got=%b want=0", f8_ov);
        end
    endtask

    task automatic test_rr();
        logic [7:0] vecs[6] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h00, 8'h81};
        int         idxs[6] = '{7, 0, 7, 0, 0, 7};
        logic       nones[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       mults[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_t e;
        r8_or = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r8_in = vecs[i];
            r8_iv = 1'b1;
            exp_q.push_back('{idxs[i], nones[i], mults[i]});
            @(posedge clk);
            #1;
            total++;
            e = exp_q.pop_front();
            if (r8_ov !== 1'b1 || r8_out !== 3'(e.idx) || r8_none !== e.none || r8_multi !== e.multi) begin
                bad++;
                $display("FAIL rr8 step=%0d got=v%b %0d/%b/%b want=v1 %0d/%b/%b",
                         i, r8_ov, r8_out, r8_none, r8_multi, e.idx, e.none, e.multi);
            end
        end
        r8_iv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_param();
        logic [15:0] v16[2] = '{16'h8001, 16'h0040};
        int          i16[2] = '{15, 6};
        logic        m16[2] = '{1'b1, 1'b0};
        exp_t e;
        g16_or = 1'b1;
        for (int i = 0; i < 2; i++) begin
            g16_in = v16[i];
            g16_iv = 1'b1;
            exp_q.push_back('{i16[i], 1'b0, m16[i]});
            @(posedge clk);
            #1;
            total++;
            e = exp_q.pop_front();
            if (g16_ov !== 1'b1 || g16_out !== 4'(e.idx) || g16_none !== e.none || g16_multi !== e.multi) begin
                bad++;
                $display("FAIL fix16 step=%0d got=v%b %0d/%b/%b want=v1 %0d/%b/%b",
                         i, g16_ov, g16_out, g16_none, g16_multi, e.idx, e.none, e.multi);
            end
        end
        g16_iv = 1'b0;
        r5_or = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r5_in = 5'b11111;
            r5_iv = 1'b1;
            exp_q.push_back('{4 - i, 1'b0, 1'b1});
            @(posedge clk);
            #1;
            total++;
            e = exp_q.pop_front();
            if (r5_ov !== 1'b1 || r5_out !== 3'(e.idx) || r5_none !== e.none || r5_multi !== e.multi) begin
                bad++;
                $display("FAIL rr5 step=%0d got=v%b %0d/%b/%b want=v1 %0d/%b/%b",
                         i, r5_ov, r5_out, r5_none, r5_multi, e.idx, e.none, e.multi);
            end
        end
        r5_iv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        exp_t e;
        // The round-robin pointer sits at 6 after the previous scenario, so bit 0 wins here.
        r8_or = 1'b0;
        r8_in = 8'h81;
        r8_iv = 1'b1;
        exp_q.push_back('{0, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        total++;
        e = exp_q.pop_front();
        if (r8_ov !== 1'b1 || r8_out !== 3'(e.idx) || r8_multi !== e.multi) begin
            bad++;
            $display("FAIL areset_pre got=v%b %0d/%b want=v1 %0d/%b", r8_ov, r8_out, r8_multi, e.idx, e.multi);
        end
        r8_iv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({r8_ov, r8_out, r8_none, r8_multi} !== 6'b0) begin
            bad++;
            $display("FAIL areset_clear got=%b want=000000", {r8_ov, r8_out, r8_none, r8_multi});
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        r8_or = 1'b1;
        r8_in = 8'h81;
        r8_iv = 1'b1;
        exp_q.push_back('{7, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        total++;
        e = exp_q.pop_front();
        if (r8_ov !== 1'b1 || r8_out !== 3'(e.idx) || r8_multi !== e.multi) begin
            bad++;
            $display("FAIL areset_post got=v%b %0d/%b want=v1 %0d/%b", r8_ov, r8_out, r8_multi, e.idx, e.multi);
        end
        r8_iv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_walk();
        test_zero_multi();
        test_backpressure();
        test_rr();
        test_param();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
